relay_sequencer: RTL and testbench

Digital break-before-make sequencer for the bank of `Relais` switch elements that route the signal path (e.g. selecting one of several AM_Mod/diode detector paths). It accepts switch requests on a valid/ready channel, opens the currently closed relay, waits for the contacts to settle past the switch hysteresis, enforces a dead gap, then closes the requested relay. At most one coil is ever energised, so two paths are never shorted together.

---
 rtl/relay_seq_pkg.sv | 34 +++
 rtl/relay_sequencer_settle_timer.sv | 30 +++
 rtl/relay_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_relay_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/relay_seq_pkg.sv
// relay_seq_pkg: shared types, timer width and one-hot helper for the relay sequencer.
`default_nettype none

package relay_seq_pkg;

  localparam int TIMER_W    = 8;
  localparam int MAX_RELAYS = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_OPEN_WAIT  = 3'd1,
    ST_GAP        = 3'd2,
    ST_CLOSE_WAIT = 3'd3,
    ST_DONE       = 3'd4
  } relay_state_t;

  // Outcome of evaluating a request against the currently closed relay.
  typedef enum logic [1:0] {
    DEC_ERR   = 2'd0,
    DEC_NOOP  = 2'd1,
    DEC_OPEN  = 2'd2,
    DEC_CLOSE = 2'd3
  } relay_dec_t;

  function automatic logic [MAX_RELAYS-1:0] onehot(input logic [3:0] sel);
    logic [MAX_RELAYS-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/relay_sequencer_settle_timer.sv
// settle_timer: loadable down-counter; expired while the count sits at 1.
`default_nettype none

module settle_timer
  import relay_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_count,
  output logic               o_expired
);

  logic [TIMER_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_count;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == TIMER_W'(1));

endmodule

`default_nettype wire

// File: rtl/relay_sequencer.sv
// relay_sequencer: break-before-make relay bank sequencer; at most one coil energised.
// Revision 1.0
`default_nettype none

module relay_sequencer
  import relay_seq_pkg::*;
#(
  parameter int N_RELAYS = 4,
  parameter int T_SETTLE = 16,
  parameter int T_GAP    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_on,
  input  logic [$clog2(N_RELAYS)-1:0] req_sel,
  output logic [N_RELAYS-1:0]         coil,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int SEL_W = $clog2(N_RELAYS);
  localparam logic [TIMER_W-1:0] c_settle_cnt = TIMER_W'(T_SETTLE);
  localparam logic [TIMER_W-1:0] c_gap_cnt    = TIMER_W'(T_GAP);

  relay_state_t          r_state;
  logic                  r_on;
  logic [N_RELAYS-1:0]   r_oh;
  logic [SEL_W-1:0]      r_sel;
  logic                  r_cur_vld;
  logic [SEL_W-1:0]      r_cur_idx;

  logic                  w_accept;
  logic [MAX_RELAYS-1:0] w_oh_full;
  logic [N_RELAYS-1:0]   w_oh_req;
  logic                  w_oor;
  relay_dec_t            w_dec;
  logic                  w_expired;
  logic                  w_tmr_load;
  logic [TIMER_W-1:0]    w_tmr_count;

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_oh_full = onehot(4'(req_sel));
  assign w_oh_req  = w_oh_full[N_RELAYS-1:0];

  // An index past the bank lands its one-hot bit above N_RELAYS-1.
  generate
    if (N_RELAYS < MAX_RELAYS) begin : g_oor
      assign w_oor = |w_oh_full[MAX_RELAYS-1:N_RELAYS];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

  always_comb begin
    w_dec = DEC_NOOP;
    if (req_on && w_oor) begin
      w_dec = DEC_ERR;
    end else if (req_on && r_cur_vld && (req_sel == r_cur_idx)) begin
      w_dec = DEC_NOOP;
    end else if (!req_on && !r_cur_vld) begin
      w_dec = DEC_NOOP;
    end else if (r_cur_vld) begin
      w_dec = DEC_OPEN;
    end else begin
      w_dec = DEC_CLOSE;
    end
  end

  // The shared timer is reloaded on the same edge that enters each wait state.
  always_comb begin
    w_tmr_load  = 1'b0;
    w_tmr_count = c_settle_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && ((w_dec == DEC_OPEN) || (w_dec == DEC_CLOSE))) begin
          w_tmr_load = 1'b1;
        end
      end
      ST_OPEN_WAIT: begin
        if (w_expired && r_on) begin
          w_tmr_load  = 1'b1;
          w_tmr_count = (T_GAP == 0) ? c_settle_cnt : c_gap_cnt;
        end
      end
      ST_GAP: begin
        if (w_expired) begin
          w_tmr_load = 1'b1;
        end
      end
      default: begin
        w_tmr_load = 1'b0;
      end
    endcase
  end

  settle_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_tmr_load),
    .i_count   (w_tmr_count),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_on      <= 1'b0;
      r_oh      <= '0;
      r_sel     <= '0;
      r_cur_vld <= 1'b0;
      r_cur_idx <= '0;
      coil      <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_on  <= req_on;
            r_oh  <= w_oh_req;
            r_sel <= req_sel;
            case (w_dec)
              DEC_ERR: begin
                done    <= 1'b1;
                err     <= 1'b1;
                r_state <= ST_DONE;
              end
              DEC_NOOP: begin
                done    <= 1'b1;
                r_state <= ST_DONE;
              end
              DEC_OPEN: begin
                coil      <= '0;
                r_cur_vld <= 1'b0;
                r_state   <= ST_OPEN_WAIT;
              end
              default: begin
                coil      <= w_oh_req;
                r_cur_vld <= 1'b1;
                r_cur_idx <= req_sel;
                r_state   <= ST_CLOSE_WAIT;
              end
            endcase
          end
        end
        ST_OPEN_WAIT: begin
          if (w_expired) begin
            if (!r_on) begin
              done    <= 1'b1;
              r_state <= ST_DONE;
            end else if (T_GAP == 0) begin
              coil      <= r_oh;
              r_cur_vld <= 1'b1;
              r_cur_idx <= r_sel;
              r_state   <= ST_CLOSE_WAIT;
            end else begin
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (w_expired) begin
            coil      <= r_oh;
            r_cur_vld <= 1'b1;
            r_cur_idx <= r_sel;
            r_state   <= ST_CLOSE_WAIT;
          end
        end
        ST_CLOSE_WAIT: begin
          if (w_expired) begin
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          err     <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          coil    <= '0;
          done    <= 1'b0;
          err     <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);

  a_coil_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(coil));

  a_break_before_make : assert property (@(posedge clk) disable iff (!rst_n)
    ((coil != '0) && ($past(coil) != '0)) |-> (coil == $past(coil)));

endmodule

`default_nettype wire

// File: tb/tb_relay_sequencer.sv
// tb_relay_sequencer: directed + randomized requests against a timing-formula reference model.
`default_nettype none

module tb_relay_sequencer;

  localparam int N  = 5;
  localparam int TS = 16;
  localparam int TG = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_on;
  logic [2:0]   req_sel;
  logic [N-1:0] coil;
  logic         busy;
  logic         done;
  logic         err;

  int n_pass  = 0;
  int n_total = 0;
  int m_cur   = -1;

  always #5 clk = ~clk;

  relay_sequencer #(
    .N_RELAYS (N),
    .T_SETTLE (TS),
    .T_GAP    (TG)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_on    (req_on),
    .req_sel   (req_sel),
    .coil      (coil),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // Called at a negedge where the sequencer should be idle; returns at the
  // negedge of the cycle after done (ready for a back-to-back request).
  task automatic do_req(input bit on, input int sel);
    int           d;
    int           sw;
    bit           e;
    logic [N-1:0] a;
    logic [N-1:0] b;
    e  = 1'b0;
    sw = 1;
    if (on && sel >= N) begin
      d = 1; e = 1'b1; a = oh(m_cur); b = a;
    end else if ((on && sel == m_cur) || (!on && m_cur < 0)) begin
      d = 1; a = oh(m_cur); b = a;
    end else if (m_cur >= 0 && on) begin
      d = 2 * TS + TG + 1; sw = TS + TG + 1; a = '0; b = oh(sel); m_cur = sel;
    end else if (m_cur >= 0) begin
      d = TS + 1; a = '0; b = '0; m_cur = -1;
    end else begin
      d = TS + 1; a = oh(sel); b = a; m_cur = sel;
    end

    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_on    = on;
    req_sel   = 3'(sel);
    @(negedge clk);
    req_valid = 1'b0;
    req_on    = 1'($urandom);
    req_sel   = 3'($urandom);
    for (int k = 1; k <= d; k++) begin
      chk("coil",  coil, (k < sw) ? a : b);
      chk("done",  done, (k == d) ? 1 : 0);
      chk("err",   err,  (k == d && e) ? 1 : 0);
      chk("busy",  busy, 1);
      chk("ready", req_ready, 0);
      @(negedge clk);
    end
    chk("ready_after", req_ready, 1);
    chk("busy_after",  busy, 0);
    chk("done_after",  done, 0);
    chk("err_after",   err, 0);
    chk("coil_after",  coil, b);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_on    = 1'b0;
    req_sel   = '0;
    repeat (3) @(negedge clk);
    chk("rst_coil",  coil, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_err",   err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b1, 2);   // close from all-open
    do_req(1'b1, 2);   // no-op, already closed
    do_req(1'b1, 0);   // switch 2 -> 0
    do_req(1'b1, 2);   // switch 0 -> 2
    do_req(1'b1, 5);   // out of range
    do_req(1'b1, 7);   // out of range
    do_req(1'b1, 1);   // switch 2 -> 1
    do_req(1'b0, 0);   // open-all
    do_req(1'b0, 3);   // open-all while open: no-op
    do_req(1'b1, 4);   // highest valid index

    // Reset in the middle of a 4 -> 2 switch, during CLOSE_WAIT.
    req_valid = 1'b1;
    req_on    = 1'b1;
    req_sel   = 3'd2;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (24) @(negedge clk);
    chk("pre_abort_coil", coil, 5'b00100);
    rst_n = 1'b0;
    #1;
    chk("abort_coil",  coil, 0);
    chk("abort_busy",  busy, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_done",  done, 0);
    m_cur = -1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b1, 3);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
